// File: rtl/linebuf_pkg.sv
// Shared definitions for the sprite line-buffer controller.
// Holds the display sequencer state type, pixel constants and parameter defaults.
package linebuf_pkg;

    localparam int DEF_ADDRWIDTH = 9;
    localparam int DEF_DATAWIDTH = 12;
    localparam int DEF_LINE_W    = 384;

    // Colour index 0 is transparent: such pixels are never written.
    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
    // Every bit of a cleared line-buffer entry takes this value.
    localparam logic       CLEAR_BIT       = 1'b0;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_CLEAR = 2'd2
    } rd_state_e;

    function automatic logic is_opaque(input logic [3:0] idx);
        return idx != TRANSPARENT_IDX;
    endfunction

endpackage

// File: rtl/linebuf_rd_fsm.sv
// Display-side read/clear sequencer for one RAM port B.
// The caller muxes port_* onto the buffer named by port_buf and feeds back
// the read data of the buffer named by rd_buf.
module linebuf_rd_fsm
    import linebuf_pkg::*;
#(
    parameter int ADDRWIDTH = DEF_ADDRWIDTH,
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int LINE_W    = DEF_LINE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_ce,
    input  logic [ADDRWIDTH-1:0] pix_x,
    input  logic                 disp_sel,
    input  logic [DATAWIDTH-1:0] q_b,
    output logic                 port_act,
    output logic                 port_buf,
    output logic [ADDRWIDTH-1:0] port_addr,
    output logic                 port_wren,
    output logic                 rd_buf,
    output logic [DATAWIDTH-1:0] pix_out,
    output logic                 pix_valid,
    output logic                 err_overrun
);

    localparam logic [ADDRWIDTH:0] LINE_W_C = (ADDRWIDTH + 1)'(LINE_W);

    rd_state_e              state_q, state_d;
    logic [ADDRWIDTH-1:0]   x_q, x_d;
    logic                   buf_q, buf_d;
    logic                   oor_q, oor_d;
    logic [DATAWIDTH-1:0]   pix_out_q, pix_out_d;
    logic                   pix_valid_q, pix_valid_d;
    logic                   err_q, err_d;
    logic                   start;
    logic                   x_in_range;

    // Next state, port B drive and pixel capture.
    // The clear is issued in READ: the RAM returns the old word that cycle and
    // the zero lands at the closing edge, leaving CLEAR free to start a new read.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        buf_d       = buf_q;
        oor_d       = oor_q;
        pix_out_d   = pix_out_q;
        pix_valid_d = 1'b0;
        err_d       = err_q;
        port_act    = 1'b0;
        port_buf    = buf_q;
        port_addr   = x_q;
        port_wren   = 1'b0;
        start       = 1'b0;
        x_in_range  = {1'b0, pix_x} < LINE_W_C;

        case (state_q)
            RD_IDLE: begin
                start = pix_ce;
            end
            RD_READ: begin
                if (pix_ce) begin
                    err_d = 1'b1;
                end
                pix_out_d   = oor_q ? '0 : q_b;
                pix_valid_d = 1'b1;
                port_act    = ~oor_q;
                port_wren   = ~oor_q;
                state_d     = RD_CLEAR;
            end
            RD_CLEAR: begin
                start   = pix_ce;
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        if (start) begin
            state_d   = RD_READ;
            x_d       = pix_x;
            buf_d     = disp_sel;
            oor_d     = ~x_in_range;
            port_act  = x_in_range;
            port_buf  = disp_sel;
            port_addr = pix_x;
        end
    end

    // Sequencer state and latched request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RD_IDLE;
            x_q         <= '0;
            buf_q       <= 1'b0;
            oor_q       <= 1'b0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            buf_q       <= buf_d;
            oor_q       <= oor_d;
            pix_out_q   <= pix_out_d;
            pix_valid_q <= pix_valid_d;
            err_q       <= err_d;
        end
    end

    // Registered outputs.
    always_comb begin
        rd_buf      = buf_q;
        pix_out     = pix_out_q;
        pix_valid   = pix_valid_q;
        err_overrun = err_q;
    end

endmodule

// File: rtl/linebuf_ctrl.sv
// Ping-pong sprite line-buffer controller driving two external dual-port RAMs.
// Port A of the render buffer takes renderer writes; port B of the display
// buffer is read then cleared per displayed pixel.
// Optional: define LINEBUF_STATS_EN to add the wr_count output.
module linebuf_ctrl
    import linebuf_pkg::*;
#(
    parameter int ADDRWIDTH = DEF_ADDRWIDTH,
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int LINE_W    = DEF_LINE_W
) (
    input  logic                 CLK,
    input  logic                 nRESET,
    input  logic                 line_swap,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDRWIDTH-1:0] wr_x,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 pix_ce,
    input  logic [ADDRWIDTH-1:0] pix_x,
    output logic [DATAWIDTH-1:0] pix_out,
    output logic                 pix_valid,
    output logic                 err_overrun,
`ifdef LINEBUF_STATS_EN
    output logic [ADDRWIDTH:0]   wr_count,
`endif
    output logic [ADDRWIDTH-1:0] buf0_addr_a,
    output logic [DATAWIDTH-1:0] buf0_data_a,
    output logic                 buf0_wren_a,
    output logic [ADDRWIDTH-1:0] buf0_addr_b,
    output logic [DATAWIDTH-1:0] buf0_data_b,
    output logic                 buf0_wren_b,
    input  logic [DATAWIDTH-1:0] buf0_q_b,
    output logic [ADDRWIDTH-1:0] buf1_addr_a,
    output logic [DATAWIDTH-1:0] buf1_data_a,
    output logic                 buf1_wren_a,
    output logic [ADDRWIDTH-1:0] buf1_addr_b,
    output logic [DATAWIDTH-1:0] buf1_data_b,
    output logic                 buf1_wren_b,
    input  logic [DATAWIDTH-1:0] buf1_q_b
);

    localparam logic [ADDRWIDTH:0] LINE_W_C = (ADDRWIDTH + 1)'(LINE_W);

    logic                 sel_q, sel_d;
    logic [ADDRWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATAWIDTH-1:0] wr_data_q, wr_data_d;
    logic                 wr_en_q, wr_en_d;
    logic                 wr_buf_q, wr_buf_d;
    logic                 accept;
    logic                 commit;

    logic                 rd_act;
    logic                 rd_port_buf;
    logic [ADDRWIDTH-1:0] rd_addr;
    logic                 rd_wren;
    logic                 rd_buf;
    logic [DATAWIDTH-1:0] rd_q;

    // Render request acceptance and buffer-select toggle.
    // The target buffer is captured with the request so a write accepted just
    // before a swap still lands in the old render buffer.
    always_comb begin
        wr_ready  = ~line_swap;
        accept    = wr_valid & ~line_swap;
        commit    = accept & ({1'b0, wr_x} < LINE_W_C) & is_opaque(wr_data[3:0]);
        sel_d     = sel_q ^ line_swap;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_buf_d  = wr_buf_q;
        wr_en_d   = commit;
        if (accept) begin
            wr_addr_d = wr_x;
            wr_data_d = wr_data;
            wr_buf_d  = sel_q;
        end
    end

    // Buffer select and registered port A request.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sel_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            wr_buf_q  <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            wr_buf_q  <= wr_buf_d;
        end
    end

    // Port A steering: only the captured target buffer sees the write.
    always_comb begin
        buf0_addr_a = wr_buf_q ? '0 : wr_addr_q;
        buf0_data_a = wr_buf_q ? '0 : wr_data_q;
        buf0_wren_a = wr_en_q & ~wr_buf_q;
        buf1_addr_a = wr_buf_q ? wr_addr_q : '0;
        buf1_data_a = wr_buf_q ? wr_data_q : '0;
        buf1_wren_a = wr_en_q & wr_buf_q;
    end

    linebuf_rd_fsm #(
        .ADDRWIDTH (ADDRWIDTH),
        .DATAWIDTH (DATAWIDTH),
        .LINE_W    (LINE_W)
    ) u_rd_fsm (
        .clk         (CLK),
        .rst_n       (nRESET),
        .pix_ce      (pix_ce),
        .pix_x       (pix_x),
        .disp_sel    (~sel_q),
        .q_b         (rd_q),
        .port_act    (rd_act),
        .port_buf    (rd_port_buf),
        .port_addr   (rd_addr),
        .port_wren   (rd_wren),
        .rd_buf      (rd_buf),
        .pix_out     (pix_out),
        .pix_valid   (pix_valid),
        .err_overrun (err_overrun)
    );

    // Port B steering and read-data select for the display sequencer.
    always_comb begin
        rd_q        = rd_buf ? buf1_q_b : buf0_q_b;
        buf0_addr_b = (rd_act && !rd_port_buf) ? rd_addr : '0;
        buf0_wren_b = rd_wren & ~rd_port_buf;
        buf0_data_b = {DATAWIDTH{CLEAR_BIT}};
        buf1_addr_b = (rd_act && rd_port_buf) ? rd_addr : '0;
        buf1_wren_b = rd_wren & rd_port_buf;
        buf1_data_b = {DATAWIDTH{CLEAR_BIT}};
    end

`ifdef LINEBUF_STATS_EN
    logic [ADDRWIDTH:0] cnt_q, cnt_d;
    logic [ADDRWIDTH:0] wr_count_q, wr_count_d;

    // Per-line opaque write counter, saturating, snapshotted on swap.
    always_comb begin
        cnt_d      = cnt_q;
        wr_count_d = wr_count_q;
        if (commit && (cnt_q != '1)) begin
            cnt_d = cnt_q + (ADDRWIDTH + 1)'(1);
        end
        if (line_swap) begin
            wr_count_d = cnt_q;
            cnt_d      = '0;
        end
    end

    // Statistics registers.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cnt_q      <= '0;
            wr_count_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Statistics output.
    always_comb begin
        wr_count = wr_count_q;
    end
`else
    // Statistics disabled: no counter state.
`endif

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Self-checking bench for linebuf_ctrl with two behavioural RAMs and a
// line-buffer content model.
module tb_linebuf_ctrl;

    localparam int AW = 9;
    localparam int DW = 12;
    localparam int LW = 384;

    logic          CLK = 1'b0;
    logic          nRESET = 1'b0;
    logic          line_swap = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_x = '0;
    logic [DW-1:0] wr_data = '0;
    logic          pix_ce = 1'b0;
    logic [AW-1:0] pix_x = '0;
    logic [DW-1:0] pix_out;
    logic          pix_valid;
    logic          err_overrun;
`ifdef LINEBUF_STATS_EN
    logic [AW:0]   wr_count;
`endif
    logic [AW-1:0] buf0_addr_a, buf0_addr_b, buf1_addr_a, buf1_addr_b;
    logic [DW-1:0] buf0_data_a, buf0_data_b, buf1_data_a, buf1_data_b;
    logic          buf0_wren_a, buf0_wren_b, buf1_wren_a, buf1_wren_b;
    logic [DW-1:0] buf0_q_b = '0;
    logic [DW-1:0] buf1_q_b = '0;

    logic [DW-1:0] mem0 [0:511] = '{default: '0};
    logic [DW-1:0] mem1 [0:511] = '{default: '0};
    // Expected line-buffer contents: refbuf[buffer][x].
    logic [DW-1:0] refbuf [0:1][0:511] = '{default: '0};
    int            model_sel = 0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    linebuf_ctrl #(
        .ADDRWIDTH (AW),
        .DATAWIDTH (DW),
        .LINE_W    (LW)
    ) dut (
        .CLK         (CLK),
        .nRESET      (nRESET),
        .line_swap   (line_swap),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_data     (wr_data),
        .pix_ce      (pix_ce),
        .pix_x       (pix_x),
        .pix_out     (pix_out),
        .pix_valid   (pix_valid),
        .err_overrun (err_overrun),
`ifdef LINEBUF_STATS_EN
        .wr_count    (wr_count),
`endif
        .buf0_addr_a (buf0_addr_a),
        .buf0_data_a (buf0_data_a),
        .buf0_wren_a (buf0_wren_a),
        .buf0_addr_b (buf0_addr_b),
        .buf0_data_b (buf0_data_b),
        .buf0_wren_b (buf0_wren_b),
        .buf0_q_b    (buf0_q_b),
        .buf1_addr_a (buf1_addr_a),
        .buf1_data_a (buf1_data_a),
        .buf1_wren_a (buf1_wren_a),
        .buf1_addr_b (buf1_addr_b),
        .buf1_data_b (buf1_data_b),
        .buf1_wren_b (buf1_wren_b),
        .buf1_q_b    (buf1_q_b)
    );

    // Two synchronous dual-port RAMs, read-before-write on port B.
    always @(posedge CLK) begin
        if (buf0_wren_a) mem0[buf0_addr_a] <= buf0_data_a;
        if (buf0_wren_b) mem0[buf0_addr_b] <= buf0_data_b;
        buf0_q_b <= mem0[buf0_addr_b];
        if (buf1_wren_a) mem1[buf1_addr_a] <= buf1_data_a;
        if (buf1_wren_b) mem1[buf1_addr_b] <= buf1_data_b;
        buf1_q_b <= mem1[buf1_addr_b];
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Model of an accepted render request: opaque and in range gets stored.
    task automatic model_write(input int x, input logic [DW-1:0] d);
        if (d[3:0] != 4'h0 && x < LW) refbuf[model_sel][x] = d;
    endtask

    // Model of a display read: returns the stored pixel and clears the entry.
    task automatic model_read(input int x, output logic [DW-1:0] d);
        int b;
        b = model_sel ^ 1;
        if (x < LW) begin
            d = refbuf[b][x];
            refbuf[b][x] = '0;
        end else begin
            d = '0;
        end
    endtask

    task automatic test_reset();
        logic any_wren;
        nRESET = 1'b0;
        step(); step();
        nRESET = 1'b1;
        step();
        wr_valid = 1'b1; wr_x = 9'd5; wr_data = 12'h0A3;
        #2 nRESET = 1'b0;
        any_wren = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            any_wren |= buf0_wren_a | buf1_wren_a | buf0_wren_b | buf1_wren_b;
        end
        wr_valid = 1'b0;
        n_checks++;
        if (any_wren !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_wren: got %b expected 0", any_wren);
        end
        n_checks++;
        if ({pix_out, pix_valid, err_overrun} !== '0) begin
            n_fail++; $display("FAIL reset_pix: got %h/%b/%b expected 0/0/0", pix_out, pix_valid, err_overrun);
        end
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready);
        end
        n_checks++;
        if ({buf0_addr_a, buf0_data_a, buf0_addr_b, buf0_data_b,
             buf1_addr_a, buf1_data_a, buf1_addr_b, buf1_data_b} !== '0) begin
            n_fail++; $display("FAIL reset_ports: got %h %h %h %h expected all 0",
                               buf0_addr_a, buf0_data_a, buf1_addr_a, buf1_data_a);
        end
`ifdef LINEBUF_STATS_EN
        n_checks++;
        if (wr_count !== '0) begin
            n_fail++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count);
        end
`endif
        #2 nRESET = 1'b1;
        step(); step();
        model_sel = 0;
        n_checks++;
        if (mem0[5] !== '0 || mem1[5] !== '0) begin
            n_fail++; $display("FAIL reset_discard: got %h/%h expected 000/000", mem0[5], mem1[5]);
        end
    endtask

    task automatic test_render_display();
        logic [DW-1:0] exp;
        wr_valid = 1'b1; wr_x = 9'd10; wr_data = 12'h123;
        model_write(10, 12'h123);
        step();
        wr_valid = 1'b0;
        n_checks++;
        if ({buf0_wren_a, buf1_wren_a, buf0_addr_a, buf0_data_a} !== {1'b1, 1'b0, 9'd10, 12'h123}) begin
            n_fail++; $display("FAIL rd_port_a: got %b %b %0d %h expected 1 0 10 123",
                               buf0_wren_a, buf1_wren_a, buf0_addr_a, buf0_data_a);
        end
        step();
        line_swap = 1'b1;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++; $display("FAIL rd_swap_ready: got %b expected 0", wr_ready);
        end
        step();
        line_swap = 1'b0;
        model_sel ^= 1;
        pix_ce = 1'b1; pix_x = 9'd10;
        model_read(10, exp);
        #1;
        n_checks++;
        if ({buf0_addr_b, buf0_wren_b, buf1_wren_b} !== {9'd10, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL rd_addr_b: got %0d %b %b expected 10 0 0", buf0_addr_b, buf0_wren_b, buf1_wren_b);
        end
        step();
        pix_ce = 1'b0;
        n_checks++;
        if ({buf0_wren_b, buf0_addr_b, buf0_data_b, buf1_wren_b} !== {1'b1, 9'd10, 12'h000, 1'b0}) begin
            n_fail++; $display("FAIL rd_clear: got %b %0d %h %b expected 1 10 000 0",
                               buf0_wren_b, buf0_addr_b, buf0_data_b, buf1_wren_b);
        end
        step();
        n_checks++;
        if ({pix_valid, pix_out} !== {1'b1, exp}) begin
            n_fail++; $display("FAIL rd_pix_out: got %b %h expected 1 %h", pix_valid, pix_out, exp);
        end
        step();
        n_checks++;
        if (pix_valid !== 1'b0 || mem0[10] !== 12'h000) begin
            n_fail++; $display("FAIL rd_after: got valid %b mem %h expected 0 000", pix_valid, mem0[10]);
        end
    endtask

    task automatic test_transparency();
        wr_valid = 1'b1; wr_x = 9'd3; wr_data = 12'h120;
        model_write(3, 12'h120);
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL tr_ready: got %b expected 1", wr_ready);
        end
        step();
        wr_x = 9'd400; wr_data = 12'h125;
        model_write(400, 12'h125);
        n_checks++;
        if ({buf0_wren_a, buf1_wren_a} !== 2'b00) begin
            n_fail++; $display("FAIL tr_transparent: got %b%b expected 00", buf0_wren_a, buf1_wren_a);
        end
        step();
        wr_valid = 1'b0;
        n_checks++;
        if ({buf0_wren_a, buf1_wren_a} !== 2'b00) begin
            n_fail++; $display("FAIL tr_range: got %b%b expected 00", buf0_wren_a, buf1_wren_a);
        end
    endtask

    task automatic test_swap_boundary();
        wr_valid = 1'b1; wr_x = 9'd20; wr_data = 12'h3C7;
        model_write(20, 12'h3C7);
        step();
        line_swap = 1'b1; wr_x = 9'd21; wr_data = 12'h5A5;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++; $display("FAIL sw_ready: got %b expected 0", wr_ready);
        end
        n_checks++;
        if ({buf1_wren_a, buf0_wren_a, buf1_addr_a, buf1_data_a} !== {1'b1, 1'b0, 9'd20, 12'h3C7}) begin
            n_fail++; $display("FAIL sw_old_buf: got %b %b %0d %h expected 1 0 20 3c7",
                               buf1_wren_a, buf0_wren_a, buf1_addr_a, buf1_data_a);
        end
        step();
        line_swap = 1'b0; wr_valid = 1'b0;
        model_sel ^= 1;
        n_checks++;
        if ({buf0_wren_a, buf1_wren_a} !== 2'b00) begin
            n_fail++; $display("FAIL sw_dropped: got %b%b expected 00", buf0_wren_a, buf1_wren_a);
        end
        step();
        n_checks++;
        if (mem1[20] !== 12'h3C7 || mem1[21] !== 12'h000) begin
            n_fail++; $display("FAIL sw_mem: got %h %h expected 3c7 000", mem1[20], mem1[21]);
        end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] exp, seen;
        int            nvalid;
        logic          sticky;
        pix_ce = 1'b1; pix_x = 9'd20;
        model_read(20, exp);
        step();
        pix_x = 9'd21;
        step();
        pix_ce = 1'b0;
        nvalid = 0; seen = '0;
        for (int i = 0; i < 4; i++) begin
            if (pix_valid === 1'b1) begin
                nvalid++; seen = pix_out;
            end
            step();
        end
        n_checks++;
        if (nvalid != 1 || seen !== exp) begin
            n_fail++; $display("FAIL ov_valid: got %0d pulses %h expected 1 pulse %h", nvalid, seen, exp);
        end
        sticky = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sticky &= err_overrun;
            step();
        end
        n_checks++;
        if (sticky !== 1'b1) begin
            n_fail++; $display("FAIL ov_sticky: got %b expected 1", sticky);
        end
        n_checks++;
        if (mem1[20] !== 12'h000) begin
            n_fail++; $display("FAIL ov_clear: got %h expected 000", mem1[20]);
        end
        #2 nRESET = 1'b0;
        step();
        n_checks++;
        if (err_overrun !== 1'b0) begin
            n_fail++; $display("FAIL ov_reset: got %b expected 0", err_overrun);
        end
        #2 nRESET = 1'b1;
        model_sel = 0;
        step();
    endtask

    task automatic test_random();
        localparam int NCYC = 3000;
        logic          p1_v, p2_v, pw_v, pw_b, idle, swap;
        logic [DW-1:0] p1_d, p2_d, pw_d, d, exp;
        logic [AW-1:0] pw_x;
        int            x, since_ce, bad0, bad1;
        p1_v = 0; p2_v = 0; pw_v = 0; pw_b = 0; p1_d = '0; p2_d = '0; pw_d = '0; pw_x = '0;
        since_ce = 2;
        for (int i = 0; i < NCYC; i++) begin
            n_checks++;
            if (pix_valid !== p2_v || (p2_v && pix_out !== p2_d)) begin
                n_fail++; $display("FAIL rnd_pix cyc %0d: got %b %h expected %b %h", i, pix_valid, pix_out, p2_v, p2_d);
            end
            n_checks++;
            if ({buf0_wren_a, buf1_wren_a} !== {pw_v & ~pw_b, pw_v & pw_b} ||
                (pw_v && !pw_b && {buf0_addr_a, buf0_data_a} !== {pw_x, pw_d}) ||
                (pw_v &&  pw_b && {buf1_addr_a, buf1_data_a} !== {pw_x, pw_d})) begin
                n_fail++; $display("FAIL rnd_wr cyc %0d: got %b%b %0d/%h %0d/%h expected buf%0d en %b %0d/%h",
                                   i, buf0_wren_a, buf1_wren_a, buf0_addr_a, buf0_data_a,
                                   buf1_addr_a, buf1_data_a, pw_b, pw_v, pw_x, pw_d);
            end
            p2_v = p1_v; p2_d = p1_d;
            idle = (i >= NCYC - 4);
            swap = !idle && ($urandom_range(0, 31) == 0);
            line_swap = swap;
            x = $urandom_range(0, 511);
            d = DW'($urandom);
            if ($urandom_range(0, 3) == 0) d[3:0] = 4'h0;
            wr_valid = !idle && ($urandom_range(0, 2) != 0);
            wr_x = AW'(x); wr_data = d;
            pw_v = 1'b0;
            if (wr_valid && !swap) begin
                pw_v = (d[3:0] != 4'h0) && (x < LW);
                pw_b = model_sel[0]; pw_x = AW'(x); pw_d = d;
                model_write(x, d);
            end
            if (!idle && since_ce >= 2 && $urandom_range(0, 2) == 0) begin
                x = $urandom_range(0, 400);
                pix_ce = 1'b1; pix_x = AW'(x);
                model_read(x, exp);
                p1_v = 1'b1; p1_d = exp; since_ce = 1;
            end else begin
                pix_ce = 1'b0; p1_v = 1'b0; since_ce++;
            end
            if (swap) model_sel ^= 1;
            step();
        end
        line_swap = 1'b0; wr_valid = 1'b0; pix_ce = 1'b0;
        step();
        n_checks++;
        if (err_overrun !== 1'b0) begin
            n_fail++; $display("FAIL rnd_err: got %b expected 0", err_overrun);
        end
        bad0 = 0; bad1 = 0;
        for (int a = 0; a < LW; a++) begin
            if (mem0[a] !== refbuf[0][a]) bad0++;
            if (mem1[a] !== refbuf[1][a]) bad1++;
        end
        n_checks++;
        if (bad0 != 0) begin
            n_fail++; $display("FAIL rnd_mem0: got %0d differing entries expected 0", bad0);
        end
        n_checks++;
        if (bad1 != 0) begin
            n_fail++; $display("FAIL rnd_mem1: got %0d differing entries expected 0", bad1);
        end
    endtask

`ifdef LINEBUF_STATS_EN
    task automatic test_stats();
        logic [DW-1:0] d;
        line_swap = 1'b1;
        step();
        line_swap = 1'b0;
        model_sel ^= 1;
        for (int i = 0; i < 10; i++) begin
            d = (i % 3 == 2) ? DW'(12'h0A0 + 12'h100 * i) : DW'(12'h0A1 + 12'h100 * i);
            wr_valid = 1'b1; wr_x = AW'(100 + i); wr_data = d;
            model_write(100 + i, d);
            step();
        end
        wr_valid = 1'b0;
        line_swap = 1'b1;
        step();
        line_swap = 1'b0;
        model_sel ^= 1;
        n_checks++;
        if (wr_count !== 10'd7) begin
            n_fail++; $display("FAIL stats_count: got %0d expected 7", wr_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_render_display();
        test_transparency();
        test_swap_boundary();
        test_overrun();
        test_random();
`ifdef LINEBUF_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/linebuf_ctrl.md
Name: linebuf_ctrl

Overview:
- Ping-pong sprite line-buffer controller that drives the port signals of two external dual-port RAMs (buffer 0, buffer 1).
- The render side writes opaque pixels for the next line into one buffer. The display side reads the current line from the other buffer and clears each entry after it is read.
- Buffer roles exchange on a line-swap pulse at h-blank.
- Sits between the sprite renderer and the palette lookup stage.

Parameters:
ADDRWIDTH, 9, line-buffer address width
DATAWIDTH, 12, pixel width; bits [11:4] palette, [3:0] colour index
LINE_W, 384, valid pixel positions 0..LINE_W-1; requires LINE_W <= 2**ADDRWIDTH

Ports:
CLK  in  1  system clock; one clock for the whole block
nRESET  in  1  asynchronous, active-low reset
line_swap  in  1  one-cycle pulse; exchange render/display roles
wr_valid  in  1  render pixel request
wr_ready  out  1  render request accepted when wr_valid && wr_ready
wr_x  in  ADDRWIDTH  render x position
wr_data  in  DATAWIDTH  render pixel
pix_ce  in  1  display pixel strobe
pix_x  in  ADDRWIDTH  display x position
pix_out  out  DATAWIDTH  display pixel
pix_valid  out  1  one-cycle pulse, pix_out updated
err_overrun  out  1  sticky protocol-violation flag
bufN_addr_a  out  ADDRWIDTH  port A address, buffer N (N=0,1)
bufN_data_a  out  DATAWIDTH  port A write data
bufN_wren_a  out  1  port A write enable
bufN_addr_b  out  ADDRWIDTH  port B address
bufN_data_b  out  DATAWIDTH  port B write data (always 0, clear value)
bufN_wren_b  out  1  port B write enable
bufN_q_b  in  DATAWIDTH  port B read data, valid the cycle after the address is presented

Behaviour:
- Reset (async assert, sync deassert):
  - sel=0 (render buffer 0, display buffer 1).
  - pix_out=0, pix_valid=0, err_overrun=0, wr_ready=1.
  - All wren=0, all addr=0, all data=0.
  - Display FSM in IDLE.
  - A request in flight when reset asserts is discarded; no RAM write occurs.
- Render path (port A of the render buffer):
  - wr_ready=0 only in the cycle line_swap=1.
  - Accepted request at cycle N drives addr_a/data_a/wren_a of buffer[sel] from registered outputs at N+1; latency 1.
  - wren_a is asserted only if wr_data[3:0]!=0 and wr_x<LINE_W. Transparent or out-of-range requests are accepted but not written.
  - The other buffer's port A always has wren_a=0.
- Swap:
  - On line_swap, sel toggles at the next edge.
  - A write accepted before the swap still lands in the old render buffer, because the buffer index is registered with the request.
- Display FSM (port B of buffer[!sel]): states IDLE, READ, CLEAR.
  - IDLE: on pix_ce, latch x and buffer index and drive addr_b=pix_x with wren_b=0 -> READ.
  - READ: capture q_b into pix_out, pulse pix_valid, drive wren_b=1 with data_b=0 at the same address -> CLEAR.
  - CLEAR: release wren_b -> IDLE. If pix_ce is seen in CLEAR, start its read -> READ.
  - Net rule: pix_ce spacing of at least 2 cycles is supported.
  - pix_ce while in READ: dropped, err_overrun set. The flag clears only on reset.
  - pix_x>=LINE_W: no RAM access; pix_out=0 and pix_valid pulses one cycle later.
- Swap during READ/CLEAR: the pending capture and clear complete on the latched (old) display buffer; new reads use the new display buffer.
- Render and display never address the same buffer in the same cycle, except the one-cycle overlap just after a swap. That overlap is allowed because the two sides use different ports.

Optional Feature:
- Macro LINEBUF_STATS_EN.
- Defined: adds output wr_count (ADDRWIDTH+1 bits), the number of opaque writes committed to the render buffer during the previous line, latched on line_swap. The internal counter resets to 0 after the swap; on wrap it saturates at all-ones.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package linebuf_pkg:
  - Display FSM state enum.
  - Constants for the transparent colour index (4'h0) and the clear value (0).
  - Defaults for LINE_W and ADDRWIDTH.
- One sub-module, linebuf_rd_fsm: display read/clear sequencer for a single port B, instantiated once with buffer-select muxing outside it.

Test Plan:
- Reset: nRESET low mid-write with wr_valid=1, wr_x=5, wr_data=12'h0A3 -> no wren on either buffer; all outputs 0, wr_ready=1.
- Render then display: write x=10 data 12'h123 with sel=0, swap, pix_ce x=10 -> pix_out=12'h123 two cycles after pix_ce; buf0 addr 10 written with 0 in the following cycle.
- Transparency/range: wr_data=12'h120 at x=3, and wr_data=12'h125 at x=400 -> both accepted, no wren_a.
- Swap boundary: write accepted in the cycle before line_swap -> lands in the old render buffer; wr_ready=0 during the swap cycle.
- Overrun: pix_ce on two consecutive cycles -> only the first produces pix_valid; err_overrun=1 and stays set until reset.
- Stats (LINEBUF_STATS_EN): 7 opaque and 3 transparent writes, then swap -> wr_count=7.
